spi_word_master: RTL and testbench
==================================

SPI_WORD_MASTER -- requirements
Module: spi_word_master

Interface
REQ-001 Parameter WIDTH, default 64: transfer length in bits, legal range 2..64.
REQ-002 Parameter CLKDIV, default 4: wb_clk_i cycles per SCK half-period, legal range 1..255.
REQ-003 wb_clk_i  in  1: single clock; all logic samples on its rising edge.
REQ-004 wb_rst_i  in  1: reset, synchronous, active-high.
REQ-005 start  in  1: transfer request, sampled only in IDLE.
REQ-006 tx_data  in  WIDTH: word to send, captured on the accepting edge.
REQ-007 busy  out  1: high from the cycle after acceptance until return to IDLE.
REQ-008 done  out  1: one-cycle pulse at transfer completion.
REQ-009 rx_data  out  WIDTH: last received word; holds between transfers.
REQ-010 cs_n  out  1: chip select, active-low.
REQ-011 sck  out  1: serial clock, SPI mode 0 (CPOL=0, CPHA=0).
REQ-012 mosi  out  1: serial data out, MSB first.
REQ-013 miso  in  1: serial data in, MSB first; assumed already synchronous to wb_clk_i.

Function
REQ-014 States SHALL be IDLE, SETUP, SCK_HI, SCK_LO, HOLD and GAP, with one shared CLKDIV down-counter and a bit counter of width clog2(WIDTH+1).
REQ-015 IDLE: when start=1 on edge 0, the block SHALL latch tx_data into the shift register and enter SETUP; cs_n=0, busy=1, mosi=tx_data[WIDTH-1] from cycle 1.
REQ-016 SETUP SHALL last CLKDIV cycles with sck=0, then enter SCK_HI.
REQ-017 Entry into SCK_HI SHALL drive sck=1 and shift miso into the LSB of the receive register on that same edge.
REQ-018 SCK_HI SHALL last CLKDIV cycles, then enter SCK_LO.
REQ-019 Entry into SCK_LO SHALL drive sck=0 and present the next TX bit on mosi on that same edge.
REQ-020 SCK_LO SHALL last CLKDIV cycles, then return to SCK_HI, or enter HOLD after the WIDTH-th falling edge.
REQ-021 Rising edge k (k=0..WIDTH-1) SHALL occur at cycle 1+(2k+1)*CLKDIV; the last falling edge SHALL occur at cycle 1+2*WIDTH*CLKDIV.
REQ-022 HOLD SHALL last CLKDIV cycles with sck=0, cs_n=0 and mosi=0.
REQ-023 Completion edge, cycle 1+(2*WIDTH+1)*CLKDIV: cs_n=1, done=1 for exactly one cycle, rx_data updated with the received word, state to GAP.
REQ-024 GAP SHALL last CLKDIV cycles with cs_n=1 and busy=1, then enter IDLE with busy=0 at cycle 1+(2*WIDTH+2)*CLKDIV.
REQ-025 start while busy=1 SHALL be ignored: no queueing and no change to the transfer in progress.
REQ-026 If start is held high continuously, the next transfer SHALL be accepted on the first IDLE cycle, so back-to-back transfers are separated by at least CLKDIV cycles of cs_n=1.
REQ-027 In IDLE and GAP, sck=0 and mosi=0.
REQ-028 sck SHALL never toggle while cs_n=1.
REQ-029 rx_data SHALL change only on the completion edge.
REQ-030 done and start in the same cycle: start SHALL be ignored, because the block is not yet in IDLE.

Reset
REQ-031 wb_rst_i=1 SHALL force on the next edge: state=IDLE, cs_n=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, all counters 0.
REQ-032 Reset mid-transfer SHALL abort with no done pulse; rx_data SHALL read 0.
REQ-033 Reset SHALL take priority over start in the same cycle.

Verification
REQ-034 Loopback: WIDTH=8, CLKDIV=2, miso=mosi, start with tx_data=8'hA5 at cycle 0 -> cs_n falls cycle 1, first sck rise cycle 3, done at cycle 35 with rx_data=8'hA5, busy low at cycle 37.
REQ-035 WIDTH=64, CLKDIV=1, miso driven from a 64'h0123_4567_89AB_CDEF model shifter, tx_data=64'hFFFF_0000_FFFF_0000 -> rx_data=64'h0123456789ABCDEF; mosi bit sequence at sck rises equals tx_data MSB-first; exactly 64 sck rises.
REQ-036 Busy-ignore: WIDTH=8, CLKDIV=2, start pulsed again at cycles 5 and 35 with tx_data=8'h3C -> only one transfer occurs, one done pulse, rx reflects the first word.
REQ-037 Reset mid-operation: assert wb_rst_i at cycle 12 of a WIDTH=8 transfer -> next edge cs_n=1, sck=0, busy=0; no done pulse; rx_data=0.
REQ-038 Back-to-back: start held high, WIDTH=8, CLKDIV=2 -> second cs_n fall at cycle 38; cs_n high for exactly 3 cycles between transfers (completion edge, GAP, IDLE accept); two done pulses 37 cycles apart.
REQ-039 Assertions across all tests: sck stays 0 whenever cs_n=1; done is never high for two consecutive cycles; mosi is stable while sck=1.

Source files
------------

// File: rtl/spi_word_master_if.sv
// Word-level SPI master bus: host handshake, received word and serial pins.
interface spi_word_master_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             cs_n;
  logic             sck;
  logic             mosi;
  logic             miso;

  // The SPI master itself
  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, cs_n, sck, mosi
  );

  // Host plus attached SPI slave
  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, cs_n, sck, mosi
  );
endinterface

// File: rtl/spi_word_master.sv
// SPI mode-0 master moving one WIDTH-bit word per request, MSB first.
// A single CLKDIV down-counter times every phase; the bit counter tracks sck rises.
module spi_word_master #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned CLKDIV = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  spi_word_master_if.master  bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_c;

  assign div_zero_c = (div_q == '0);

  // State, counters, shift registers and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state and next register values; each phase ends when the divider hits zero
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      div_d = div_zero_c ? DIV_LOAD : (div_q - CNT_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          div_d   = DIV_LOAD;
          bit_d   = '0;
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = bus.tx_data[WIDTH-1];
        end
      end
      SETUP: begin
        if (div_zero_c) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.miso};
          bit_d   = bit_q + BIT_W'(1);
        end
      end
      SCK_HI: begin
        if (div_zero_c) begin
          sck_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            // The last falling edge leads straight into HOLD
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d = SCK_LO;
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
            mosi_d  = tx_sr_q[WIDTH-2];
          end
        end
      end
      SCK_LO: begin
        if (div_zero_c) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.miso};
          bit_d   = bit_q + BIT_W'(1);
        end
      end
      HOLD: begin
        if (div_zero_c) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end
      GAP: begin
        if (div_zero_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
endmodule

// File: tb/tb_spi_word_master.sv
// Bench for spi_word_master: an 8-bit/div-2 and a 64-bit/div-1 instance,
// compared against transfer timing and data derived from the cycle formulas.
module tb_spi_word_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [63:0] tx;
  int          sel;
  bit          loop_en;
  logic [63:0] sw;
  int          w;
  int          rise_cnt;
  logic        mv;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_rx_a, exp_rx_b;

  spi_word_master_if #(.WIDTH(8))  ia ();
  spi_word_master_if #(.WIDTH(64)) ib ();

  spi_word_master #(.WIDTH(8), .CLKDIV(2)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ia)
  );

  spi_word_master #(.WIDTH(64), .CLKDIV(1)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ib)
  );

  // Slave model: bit (w-1-k) is on miso until sck rise k has been seen
  assign mv         = (rise_cnt < w) ? sw[6'(w - 1 - rise_cnt)] : 1'b0;
  assign ia.start   = start && (sel == 0);
  assign ia.tx_data = tx[7:0];
  assign ia.miso    = loop_en ? ia.mosi : mv;
  assign ib.start   = start && (sel == 1);
  assign ib.tx_data = tx;
  assign ib.miso    = loop_en ? ib.mosi : mv;

  logic        cs_s, sck_s, mosi_s, busy_s, done_s;
  logic [63:0] rx_s;
  assign cs_s   = (sel == 1) ? ib.cs_n : ia.cs_n;
  assign sck_s  = (sel == 1) ? ib.sck  : ia.sck;
  assign mosi_s = (sel == 1) ? ib.mosi : ia.mosi;
  assign busy_s = (sel == 1) ? ib.busy : ia.busy;
  assign done_s = (sel == 1) ? ib.done : ia.done;
  assign rx_s   = (sel == 1) ? ib.rx_data : {56'd0, ia.rx_data};

  // Continuous protocol properties on both instances
  bit   mon_en = 1'b0;
  int   sck_cs_bad = 0, done2_bad = 0, mosi_bad = 0;
  logic pa_done = 1'b0, pa_sck = 1'b0, pa_mosi = 1'b0;
  logic pb_done = 1'b0, pb_sck = 1'b0, pb_mosi = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      sck_cs_bad <= sck_cs_bad + int'(ia.cs_n & ia.sck) + int'(ib.cs_n & ib.sck);
      done2_bad  <= done2_bad + int'(ia.done & pa_done) + int'(ib.done & pb_done);
      mosi_bad   <= mosi_bad + int'(pa_sck & ia.sck & (ia.mosi != pa_mosi))
                             + int'(pb_sck & ib.sck & (ib.mosi != pb_mosi));
    end
    pa_done <= ia.done; pa_sck <= ia.sck; pa_mosi <= ia.mosi;
    pb_done <= ib.done; pb_sck <= ib.sck; pb_mosi <= ib.mosi;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  // One transfer on instance s; start issued in cycle 0, cycles counted from there
  task automatic run_xfer(input int s, input logic [63:0] t, input logic [63:0] slave_w,
                          input bit lb, input int n_cyc, input int start_until,
                          input int p1, input int p2, input int rst_at, input string tag);
    int          cd, nf_last, rx_bad, rt_bad, exp_dones;
    int          rises[$];
    int          dones[$];
    int          cs_fall[$];
    int          cs_rise[$];
    int          busy_fall[$];
    logic [63:0] rx_done[$];
    logic [63:0] mosi_bits, mask, exp_word, cur_rx;
    logic        cs_p, sck_p, busy_p;

    sel      = s;
    w        = (s == 1) ? 64 : 8;
    cd       = (s == 1) ? 1 : 2;
    mask     = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    exp_word = (lb ? t : slave_w) & mask;
    cur_rx   = (s == 1) ? exp_rx_b : exp_rx_a;
    loop_en  = lb;
    sw       = slave_w;
    rise_cnt = 0;
    mosi_bits = '0;
    nf_last  = -1;
    rx_bad   = 0;
    rt_bad   = 0;
    exp_dones = (start_until > 0) ? 2 : 1;

    @(negedge clk);
    cs_p   = cs_s;
    sck_p  = sck_s;
    busy_p = busy_s;
    tx     = t;
    start  = 1'b1;
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      if (cs_p && !cs_s) cs_fall.push_back(c);
      if (!cs_p && cs_s) cs_rise.push_back(c);
      if (dones.size() == 0 && !sck_p && sck_s) begin
        rises.push_back(c);
        mosi_bits = {mosi_bits[62:0], mosi_s};
        rise_cnt++;
      end
      if (dones.size() == 0 && sck_p && !sck_s) nf_last = c;
      if (busy_p && !busy_s) busy_fall.push_back(c);
      if (done_s) begin
        dones.push_back(c);
        rx_done.push_back(rx_s);
        cur_rx = exp_word;
      end
      if (c == rst_at) check({tag, "_pre_rst_cs"}, 64'(cs_s), 64'd0);
      if (c == rst_at + 1) begin
        check({tag, "_rst_cs"},   64'(cs_s),   64'd1);
        check({tag, "_rst_sck"},  64'(sck_s),  64'd0);
        check({tag, "_rst_busy"}, 64'(busy_s), 64'd0);
        check({tag, "_rst_rx"},   rx_s,        64'd0);
        cur_rx = '0;
      end else if (rx_s != cur_rx) begin
        rx_bad++;
      end
      start = (c <= start_until) || (c == p1) || (c == p2);
      if (c == p1 || c == p2) tx = 64'h3C;
      rst   = (c == rst_at);
      cs_p   = cs_s;
      sck_p  = sck_s;
      busy_p = busy_s;
    end
    start = 1'b0;
    rst   = 1'b0;

    if (rst_at >= 0) begin
      check({tag, "_no_done"}, 64'(dones.size()), 64'd0);
      exp_rx_a = '0;
      exp_rx_b = '0;
    end else begin
      foreach (rises[k]) if (rises[k] != 1 + (2 * k + 1) * cd) rt_bad++;
      check({tag, "_cs_fall"},    64'(q_at(cs_fall, 0)), 64'd1);
      check({tag, "_n_rise"},     64'(rises.size()), 64'(w));
      check({tag, "_rise_time"},  64'(rt_bad), 64'd0);
      check({tag, "_last_fall"},  64'(nf_last), 64'(1 + 2 * w * cd));
      check({tag, "_mosi"},       mosi_bits, t & mask);
      check({tag, "_n_done"},     64'(dones.size()), 64'(exp_dones));
      check({tag, "_done_cyc"},   64'(q_at(dones, 0)), 64'(1 + (2 * w + 1) * cd));
      check({tag, "_rx"},         (rx_done.size() > 0) ? rx_done[0] : 64'hDEAD, exp_word);
      check({tag, "_busy_fall"},  64'(q_at(busy_fall, 0)), 64'(1 + (2 * w + 2) * cd));
      check({tag, "_rx_hold"},    64'(rx_bad), 64'd0);
      if (start_until > 0) begin
        check({tag, "_cs_fall2"}, 64'(q_at(cs_fall, 1)), 64'(2 + (2 * w + 2) * cd));
        check({tag, "_done_gap"}, 64'(q_at(dones, 1) - q_at(dones, 0)), 64'((2 * w + 2) * cd + 1));
        check({tag, "_cs_high"},  64'(q_at(cs_fall, 1) - q_at(cs_rise, 0)), 64'(cd + 1));
      end
      if (p1 >= 0) check({tag, "_one_xfer"}, 64'(cs_fall.size()), 64'd1);
      if (s == 1) exp_rx_b = exp_word;
      else        exp_rx_a = exp_word;
    end
  endtask

  initial begin
    logic [63:0] rt, rs;
    int          rsel;
    rst = 1'b1; start = 1'b1; tx = 64'hFF; sel = 0; w = 8;
    loop_en = 1'b0; sw = '0; rise_cnt = 0;
    exp_rx_a = '0; exp_rx_b = '0;

    // Reset with start asserted: reset wins
    repeat (3) @(negedge clk);
    check("rst_cs_a",   64'(ia.cs_n),    64'd1);
    check("rst_sck_a",  64'(ia.sck),     64'd0);
    check("rst_mosi_a", 64'(ia.mosi),    64'd0);
    check("rst_busy_a", 64'(ia.busy),    64'd0);
    check("rst_done_a", 64'(ia.done),    64'd0);
    check("rst_rx_a",   64'(ia.rx_data), 64'd0);
    check("rst_cs_b",   64'(ib.cs_n),    64'd1);
    check("rst_busy_b", 64'(ib.busy),    64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run_xfer(0, 64'hA5, 64'h0, 1'b1, 40, 0, -1, -1, -1, "loop_a5");
    run_xfer(1, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 1'b0, 134, 0, -1, -1, -1, "w64");
    run_xfer(0, 64'h96, 64'h0, 1'b1, 42, 0, 5, 35, -1, "busy_ign");
    run_xfer(0, 64'h5A, 64'h0, 1'b1, 20, 0, -1, -1, 12, "mid_rst");
    run_xfer(0, 64'hC3, 64'h0, 1'b1, 77, 37, -1, -1, -1, "b2b");

    for (int i = 0; i < 12; i++) begin
      rsel = int'($urandom_range(0, 1));
      rt   = {$urandom, $urandom};
      rs   = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_xfer(rsel, rt, rs, 1'b0, (rsel == 1) ? 133 : 39, 0, -1, -1, -1,
               (rsel == 1) ? "rnd_b" : "rnd_a");
    end

    repeat (2) @(negedge clk);
    check("sck_while_cs_hi", 64'(sck_cs_bad), 64'd0);
    check("done_twice",      64'(done2_bad),  64'd0);
    check("mosi_stable",     64'(mosi_bad),   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
